set_job_dispatcher: RTL and testbench

- Initiator/host side of the SET engine interface (en, central, radius, mode in; busy, valid, candidate out).
- Buffers jobs from a host-side valid/ready port in a small FIFO and issues them to the engine one at a time.
- Waits for the engine's result pulse and returns the candidate count with a sequence tag on a valid/ready result port.
- Includes a watchdog so a hung engine cannot stall the pipeline.

---
 rtl/set_job_dispatcher_if.sv | 48 ++++
 rtl/set_job_dispatcher.sv | 210 +++++++++++++++++++++
 tb/tb_set_job_dispatcher.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/set_job_dispatcher_if.sv
// set_job_dispatcher_if
//   Bundles the three channels around the SET job dispatcher:
//     job_*  : host -> dispatcher job offer (valid/ready)
//     set_*  : dispatcher <-> SET engine (start strobe, fields, busy, result)
//     res_*  : dispatcher -> host result (valid/ready)
//   Modports:
//     master : the environment (host plus engine) driving the dispatcher
//     slave  : the dispatcher itself
interface set_job_dispatcher_if;
  // host job channel
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  // engine channel
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  // host result channel
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_timeout;

  modport master (
    output job_valid, job_central, job_radius, job_mode,
    input  job_ready,
    input  set_en, set_central, set_radius, set_mode,
    output set_busy, set_valid, set_candidate,
    input  res_valid, res_candidate, res_tag, res_timeout,
    output res_ready
  );

  modport slave (
    input  job_valid, job_central, job_radius, job_mode,
    output job_ready,
    output set_en, set_central, set_radius, set_mode,
    input  set_busy, set_valid, set_candidate,
    output res_valid, res_candidate, res_tag, res_timeout,
    input  res_ready
  );
endinterface

// File: rtl/set_job_dispatcher.sv
// set_job_dispatcher
//   Host-side initiator for the SET engine. Jobs offered on the host port
//   are buffered in a DEPTH-entry FIFO and issued to the engine one at a
//   time. The engine's single-cycle result pulse (or a watchdog expiry after
//   TIMEOUT cycles of waiting) is captured into a one-entry result slot
//   carrying a 4-bit sequence tag.
//   Ports:
//     clk : clock, everything on the rising edge
//     rst : synchronous active-high reset
//     bus : set_job_dispatcher_if.slave (job_*, set_*, res_* channels)
//   All outputs are driven straight from registers.
module set_job_dispatcher #(
  parameter int DEPTH   = 4,     // FIFO entries, power of two, 2..16
  parameter int TIMEOUT = 1024,  // cycles in WAIT before a forced timeout result
  parameter int TW      = 11     // watchdog width, must hold TIMEOUT-1
) (
  input  logic                  clk,
  input  logic                  rst,
  set_job_dispatcher_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 24 + 12 + 2;  // {central, radius, mode}
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     count_reg, count_next;
  logic            job_ready_reg, job_ready_next;

  logic [EW-1:0]   set_fields_reg;
  logic            set_en_reg, set_en_next;
  logic [TW-1:0]   wd_reg, wd_next;
  logic [3:0]      tag_reg, tag_next;

  logic            res_valid_reg, res_valid_next;
  logic [7:0]      res_cand_reg, res_cand_next;
  logic [3:0]      res_tag_reg, res_tag_next;
  logic            res_timeout_reg, res_timeout_next;

  logic            push;
  logic            pop;

  // A push is only ever attempted against the registered ready, which is
  // exactly !full for the current occupancy, so a full FIFO drops the offer.
  assign push = bus.job_valid && job_ready_reg;

  // Dispatch needs a queued job, an idle engine and a free result slot; the
  // pop of the FIFO head happens on the same edge as the move to ISSUE.
  assign pop = (state_reg == IDLE) && (count_reg != '0) &&
               !bus.set_busy && !res_valid_reg;

  // ---------------------------------------------------------------------------
  // FIFO storage: plain array, written on push, head read registered straight
  // into the engine field register on pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= {bus.job_central, bus.job_radius, bus.job_mode};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_fields_reg <= '0;
    end else if (pop) begin
      set_fields_reg <= mem[rd_ptr_reg];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer / occupancy bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
    job_ready_next = (count_next != FULL_CNT);
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM and result slot, next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    set_en_next      = 1'b0;
    wd_next          = wd_reg;
    tag_next         = tag_reg;
    res_valid_next   = res_valid_reg;
    res_cand_next    = res_cand_reg;
    res_tag_next     = res_tag_reg;
    res_timeout_next = res_timeout_reg;

    // Host consumes the held result.
    if (res_valid_reg && bus.res_ready) begin
      res_valid_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        // set_valid is deliberately ignored here, so a late or stray engine
        // pulse can never fabricate a result.
        if (pop) begin
          state_next  = ISSUE;
          set_en_next = 1'b1;
        end
      end

      ISSUE: begin
        state_next = WAIT;
        wd_next    = '0;
      end

      WAIT: begin
        wd_next = wd_reg + TW'(1);
        // The engine result wins over a watchdog expiry on the same edge.
        if (bus.set_valid) begin
          state_next       = IDLE;
          res_valid_next   = 1'b1;
          res_cand_next    = bus.set_candidate;
          res_tag_next     = tag_reg;
          res_timeout_next = 1'b0;
          tag_next         = tag_reg + 4'd1;
        end else if (wd_reg == WD_LAST) begin
          state_next       = IDLE;
          res_valid_next   = 1'b1;
          res_cand_next    = 8'd0;
          res_tag_next     = tag_reg;
          res_timeout_next = 1'b1;
          tag_next         = tag_reg + 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      job_ready_reg   <= 1'b1;
      set_en_reg      <= 1'b0;
      wd_reg          <= '0;
      tag_reg         <= 4'd0;
      res_valid_reg   <= 1'b0;
      res_cand_reg    <= 8'd0;
      res_tag_reg     <= 4'd0;
      res_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      job_ready_reg   <= job_ready_next;
      set_en_reg      <= set_en_next;
      wd_reg          <= wd_next;
      tag_reg         <= tag_next;
      res_valid_reg   <= res_valid_next;
      res_cand_reg    <= res_cand_next;
      res_tag_reg     <= res_tag_next;
      res_timeout_reg <= res_timeout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.job_ready     = job_ready_reg;
  assign bus.set_en        = set_en_reg;
  assign bus.set_central   = set_fields_reg[EW-1 -: 24];
  assign bus.set_radius    = set_fields_reg[13:2];
  assign bus.set_mode      = set_fields_reg[1:0];
  assign bus.res_valid     = res_valid_reg;
  assign bus.res_candidate = res_cand_reg;
  assign bus.res_tag       = res_tag_reg;
  assign bus.res_timeout   = res_timeout_reg;

endmodule

// File: tb/tb_set_job_dispatcher.sv
// tb_set_job_dispatcher
//   Self-checking bench for set_job_dispatcher (DEPTH=4, TIMEOUT=16).
//   A cycle-stepping task runs a simple engine model and a queue-based
//   reference (job FIFO, expected-result queue, tag counter) on every edge;
//   a vector table and a few hand sequences add exact latency checks, and a
//   random phase exercises busy/backpressure/hang mixes.
module tb_set_job_dispatcher;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_job_dispatcher_if bus();

  set_job_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // delay: engine answers delay cycles after sampling set_en; 0 = engine hangs
  typedef struct {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    int          delay;
    logic [7:0]  cand;
  } job_t;

  typedef struct {
    logic [7:0] cand;
    logic [3:0] tag;
    logic       timeout;
  } res_t;

  typedef struct {
    job_t       job;
    logic [7:0] exp_cand;
    logic       exp_to;
    logic [3:0] exp_tag;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  job_t model_q[$];
  res_t exp_res[$];
  job_t cur_job;
  logic [3:0] model_tag = 4'd0;
  bit   outstanding = 1'b0;
  bit   model_ok = 1'b0;
  bit   accepted = 1'b0;
  int   eng_cnt = -1;
  logic [7:0] eng_cand = 8'd0;
  int   en_count = 0;
  int   res_count = 0;
  int   last_en_cyc = 0;
  int   last_rv_cyc = 0;
  logic [3:0] res_tags[$];
  res_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic job_t mk_job(input logic [23:0] c, input logic [11:0] r,
                                  input logic [1:0] m, input int d, input logic [7:0] k);
    job_t j;
    j.central = c; j.radius = r; j.mode = m; j.delay = d; j.cand = k;
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j.central = 24'($urandom);
    j.radius  = 12'($urandom);
    j.mode    = 2'($urandom);
    j.delay   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
    j.cand    = 8'($urandom);
    return j;
  endfunction

  task automatic offer(input job_t j);
    cur_job         = j;
    bus.job_valid   = 1'b1;
    bus.job_central = j.central;
    bus.job_radius  = j.radius;
    bus.job_mode    = j.mode;
  endtask

  // One clock edge: remember pre-edge drive/observations, advance, then run
  // the engine model and the reference checks on the post-edge outputs.
  task automatic step();
    bit   p_jv, p_room, p_busy, p_rv, p_rr, p_rst, p_en;
    job_t p_job, h;
    res_t r;
    p_jv   = bus.job_valid;
    p_busy = bus.set_busy;
    p_rv   = bus.res_valid;
    p_rr   = bus.res_ready;
    p_rst  = rst;
    p_en   = bus.set_en;
    p_job  = cur_job;
    p_room = (model_q.size() < DEPTH);
    if (model_ok && !p_rst) check("job_ready", {31'd0, bus.job_ready}, {31'd0, p_room});

    @(posedge clk);
    #1;
    cyc++;
    accepted = 1'b0;

    if (p_rst) begin
      model_q.delete();
      exp_res.delete();
      model_tag     = 4'd0;
      outstanding   = 1'b0;
      eng_cnt       = -1;
      bus.set_valid = 1'b0;
      model_ok      = 1'b1;
      return;
    end

    // engine model: single-cycle result pulse
    bus.set_valid = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.set_valid     = 1'b1;
        bus.set_candidate = eng_cand;
        eng_cnt           = -1;
      end
    end

    if (bus.set_en) begin
      en_count++;
      last_en_cyc = cyc;
      check("en_single_pulse", {31'd0, p_en}, 32'd0);
      check("en_while_busy", {31'd0, p_busy}, 32'd0);
      check("en_while_result_held", {31'd0, p_rv}, 32'd0);
      check("en_while_outstanding", {31'd0, outstanding}, 32'd0);
      check("fifo_nonempty_at_en", {31'd0, (model_q.size() != 0)}, 32'd1);
      if (model_q.size() != 0) begin
        h = model_q.pop_front();
        check("set_central", {8'd0, bus.set_central}, {8'd0, h.central});
        check("set_radius", {20'd0, bus.set_radius}, {20'd0, h.radius});
        check("set_mode", {30'd0, bus.set_mode}, {30'd0, h.mode});
        if (h.delay >= 1) begin
          eng_cnt  = h.delay;
          eng_cand = h.cand;
        end
        r.timeout = !(h.delay >= 1 && h.delay <= TIMEOUT);
        r.cand    = r.timeout ? 8'd0 : h.cand;
        r.tag     = model_tag;
        exp_res.push_back(r);
        model_tag   = model_tag + 4'd1;
        outstanding = 1'b1;
      end
    end

    if (p_jv && p_room) begin
      model_q.push_back(p_job);
      accepted = 1'b1;
    end

    if (bus.res_valid && !p_rv) begin
      res_count++;
      last_rv_cyc = cyc;
      check("result_expected", {31'd0, (exp_res.size() != 0)}, 32'd1);
      if (exp_res.size() != 0) begin
        r = exp_res.pop_front();
        check("res_candidate", {24'd0, bus.res_candidate}, {24'd0, r.cand});
        check("res_tag", {28'd0, bus.res_tag}, {28'd0, r.tag});
        check("res_timeout", {31'd0, bus.res_timeout}, {31'd0, r.timeout});
      end
      res_tags.push_back(bus.res_tag);
      held.cand    = bus.res_candidate;
      held.tag     = bus.res_tag;
      held.timeout = bus.res_timeout;
      outstanding  = 1'b0;
    end else if (p_rv) begin
      check("res_valid_hold_or_clear", {31'd0, bus.res_valid}, {31'd0, !p_rr});
      if (bus.res_valid) begin
        check("res_stable", {19'd0, bus.res_candidate, bus.res_tag, bus.res_timeout},
              {19'd0, held.cand, held.tag, held.timeout});
      end
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.job_valid = 1'b0;
    bus.set_busy  = 1'b0;
    bus.res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_en(input int target, input int limit, input string name);
    int n = 0;
    while (en_count < target && n < limit) begin step(); n++; end
    check(name, {31'd0, (en_count >= target)}, 32'd1);
  endtask

  task automatic wait_res(input int target, input int limit, input string name);
    int n = 0;
    while (res_count < target && n < limit) begin step(); n++; end
    check(name, {31'd0, (res_count >= target)}, 32'd1);
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int base_en, base_res, push_cyc, mark, n;

    bus.job_valid     = 1'b0;
    bus.job_central   = '0;
    bus.job_radius    = '0;
    bus.job_mode      = '0;
    bus.set_busy      = 1'b0;
    bus.set_valid     = 1'b0;
    bus.set_candidate = '0;
    bus.res_ready     = 1'b0;
    cur_job           = mk_job(24'd0, 12'd0, 2'd0, 1, 8'd0);

    vecs[0] = '{job: mk_job(24'h448000, 12'h300, 2'd0, 14, 8'h1D), exp_cand: 8'h1D, exp_to: 1'b0, exp_tag: 4'd0};
    vecs[1] = '{job: mk_job(24'h123456, 12'hABC, 2'd1, 1, 8'h05), exp_cand: 8'h05, exp_to: 1'b0, exp_tag: 4'd1};
    vecs[2] = '{job: mk_job(24'hFEDCBA, 12'h0FF, 2'd2, TIMEOUT, 8'h77), exp_cand: 8'h77, exp_to: 1'b0, exp_tag: 4'd2};
    vecs[3] = '{job: mk_job(24'h0F0F0F, 12'h111, 2'd3, 0, 8'h99), exp_cand: 8'h00, exp_to: 1'b1, exp_tag: 4'd3};
    vecs[4] = '{job: mk_job(24'h000001, 12'h001, 2'd0, 3, 8'hFF), exp_cand: 8'hFF, exp_to: 1'b0, exp_tag: 4'd4};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_set_en", {31'd0, bus.set_en}, 32'd0);
    check("rst_set_fields", {2'd0, bus.set_central, bus.set_radius, bus.set_mode}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_fields", {19'd0, bus.res_candidate, bus.res_tag, bus.res_timeout}, 32'd0);
    check("rst_job_ready", {31'd0, bus.job_ready}, 32'd1);

    // ---------------- table-driven single jobs ----------------
    for (int i = 0; i < 5; i++) begin
      base_en  = en_count;
      base_res = res_count;
      offer(vecs[i].job);
      step();
      push_cyc = cyc;
      bus.job_valid = 1'b0;
      wait_en(base_en + 1, 10, "vec_en_seen");
      check("vec_issue_latency", 32'(last_en_cyc - push_cyc), 32'd1);
      wait_res(base_res + 1, TIMEOUT + 10, "vec_res_seen");
      check("vec_res_latency", 32'(last_rv_cyc - last_en_cyc),
            vecs[i].exp_to ? 32'(TIMEOUT + 1) : 32'(vecs[i].job.delay + 1));
      check("vec_candidate", {24'd0, bus.res_candidate}, {24'd0, vecs[i].exp_cand});
      check("vec_timeout", {31'd0, bus.res_timeout}, {31'd0, vecs[i].exp_to});
      check("vec_tag", {28'd0, bus.res_tag}, {28'd0, vecs[i].exp_tag});
      $display("vec %0d: central=%06h mode=%0d -> cand=%02h tag=%0d timeout=%0d", i,
               vecs[i].job.central, vecs[i].job.mode, bus.res_candidate, bus.res_tag, bus.res_timeout);
      consume();
      check("vec_res_cleared", {31'd0, bus.res_valid}, 32'd0);
    end

    // ---------------- fill FIFO to DEPTH, fifth waits ----------------
    do_reset();
    bus.set_busy  = 1'b1;
    bus.res_ready = 1'b1;
    base_en  = en_count;
    base_res = res_count;
    res_tags.delete();
    for (int j = 0; j < DEPTH; j++) begin
      offer(mk_job(24'(j * 24'h111111), 12'(j + 1), 2'(j), 2, 8'(8'h10 + j)));
      step();
    end
    bus.job_valid = 1'b0;
    check("fill_job_ready_low", {31'd0, bus.job_ready}, 32'd0);
    offer(mk_job(24'hABCDEF, 12'h555, 2'd3, 2, 8'h5A));
    step(); step(); step();
    check("fill_fifth_not_taken", {31'd0, accepted}, 32'd0);
    check("fill_no_en_while_busy", 32'(en_count - base_en), 32'd0);
    bus.set_busy = 1'b0;
    n = 0;
    while (!accepted && n < 20) begin step(); n++; end
    check("fill_fifth_accepted", {31'd0, accepted}, 32'd1);
    bus.job_valid = 1'b0;
    wait_res(base_res + 5, 200, "fill_all_results");
    check("fill_en_count", 32'(en_count - base_en), 32'd5);
    for (int j = 0; j < 5 && j < res_tags.size(); j++) begin
      check("fill_tag_order", {28'd0, res_tags[j]}, 32'(j));
    end
    $display("fill: %0d jobs issued, %0d results", en_count - base_en, res_count - base_res);
    bus.res_ready = 1'b0;

    // ---------------- result backpressure stalls dispatch ----------------
    do_reset();
    base_en  = en_count;
    base_res = res_count;
    offer(mk_job(24'h111111, 12'h222, 2'd1, 3, 8'h31));
    step();
    offer(mk_job(24'h333333, 12'h444, 2'd2, 3, 8'h32));
    step();
    bus.job_valid = 1'b0;
    wait_res(base_res + 1, 20, "bp_first_result");
    repeat (8) step();
    check("bp_no_second_en", 32'(en_count - base_en), 32'd1);
    check("bp_res_held", {31'd0, bus.res_valid}, 32'd1);
    consume();
    mark = cyc;
    check("bp_res_cleared", {31'd0, bus.res_valid}, 32'd0);
    wait_en(base_en + 2, 10, "bp_second_en");
    check("bp_second_en_timing", 32'(last_en_cyc - mark), 32'd1);
    wait_res(base_res + 2, 20, "bp_second_result");
    check("bp_second_tag", {28'd0, bus.res_tag}, 32'd1);
    $display("backpressure: second issue %0d cycle(s) after release", last_en_cyc - mark);
    consume();

    // ---------------- set_busy blocks issue ----------------
    do_reset();
    bus.set_busy = 1'b1;
    base_en  = en_count;
    base_res = res_count;
    offer(mk_job(24'h0A0B0C, 12'h123, 2'd3, 2, 8'h44));
    step();
    bus.job_valid = 1'b0;
    repeat (10) step();
    check("busy_no_en", 32'(en_count - base_en), 32'd0);
    bus.set_busy = 1'b0;
    mark = cyc;
    wait_en(base_en + 1, 10, "busy_en_after_release");
    check("busy_en_timing", 32'(last_en_cyc - mark), 32'd1);
    wait_res(base_res + 1, 20, "busy_result");
    $display("busy: issued %0d cycle(s) after set_busy fell", last_en_cyc - mark);
    consume();

    // ---------------- reset during WAIT, stray set_valid ----------------
    do_reset();
    bus.res_ready = 1'b1;
    base_en = en_count;
    for (int j = 0; j < 3; j++) begin
      offer(mk_job(24'(24'h200000 + j), 12'h0AA, 2'd1, 0, 8'h66));
      step();
    end
    bus.job_valid = 1'b0;
    wait_en(base_en + 1, 10, "rstw_en");
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_set_en", {31'd0, bus.set_en}, 32'd0);
    check("rstw_set_fields", {2'd0, bus.set_central, bus.set_radius, bus.set_mode}, 32'd0);
    check("rstw_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rstw_res_fields", {19'd0, bus.res_candidate, bus.res_tag, bus.res_timeout}, 32'd0);
    check("rstw_job_ready", {31'd0, bus.job_ready}, 32'd1);
    base_en  = en_count;
    base_res = res_count;
    bus.set_valid     = 1'b1;
    bus.set_candidate = 8'h55;
    step(); step(); step();
    check("rstw_stray_ignored", {31'd0, bus.res_valid}, 32'd0);
    check("rstw_queue_flushed", 32'(en_count - base_en), 32'd0);
    offer(mk_job(24'h765432, 12'h321, 2'd2, 2, 8'h42));
    step();
    bus.job_valid = 1'b0;
    wait_res(base_res + 1, 20, "rstw_new_result");
    check("rstw_tag_restart", {28'd0, bus.res_tag}, 32'd0);
    check("rstw_new_cand", {24'd0, bus.res_candidate}, 32'h42);
    $display("reset-in-wait: new job tag=%0d cand=%02h", bus.res_tag, bus.res_candidate);
    step();
    bus.res_ready = 1'b0;

    // ---------------- randomized mix against the reference ----------------
    do_reset();
    base_en = en_count;
    for (int c = 0; c < 1500; c++) begin
      bus.set_busy  = ($urandom_range(0, 3) == 0);
      bus.res_ready = ($urandom_range(0, 2) != 0);
      if (!bus.job_valid || accepted) begin
        if ($urandom_range(0, 1) == 1) offer(rand_job());
        else bus.job_valid = 1'b0;
      end
      step();
    end
    bus.job_valid = 1'b0;
    bus.set_busy  = 1'b0;
    bus.res_ready = 1'b1;
    n = 0;
    while ((model_q.size() != 0 || outstanding || bus.res_valid) && n < 600) begin
      step();
      n++;
    end
    check("random_drained", {31'd0, (model_q.size() == 0 && !outstanding && !bus.res_valid)}, 32'd1);
    $display("random: %0d jobs issued", en_count - base_en);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
